// File: rtl/segs_arbiter.sv
// segs_arbiter: shares the six-digit seven-segment display between three
// requesters. Round-robin arbitration with a minimum hold time per owner,
// latched display value and per-digit enables with optional leading-zero
// blanking.
//
// Ports:
//   Clock           system clock
//   Reset           asynchronous, active-high reset
//   Req[2:0]        per-requester display request (level)
//   ReqData[71:0]   requester i value in bits [24i+23:24i]
//   BlankZeros      1 = suppress leading zero digits
//   Clear           pulse: drop owner and blank the display
//   Grant[2:0]      one-hot current owner, 0 when idle
//   Data[23:0]      latched display value
//   DisplayEnables  per-digit enable
//   HoldDone        hold counter of current owner has expired
module segs_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [2:0]  Req,
    input  logic [71:0] ReqData,
    input  logic        BlankZeros,
    input  logic        Clear,
    output logic [2:0]  Grant,
    output logic [23:0] Data,
    output logic [5:0]  DisplayEnables,
    output logic        HoldDone
);

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned DATA_W  = 24;
    localparam int unsigned DIGITS  = 6;
    localparam int unsigned CNT_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t                            state;
    logic [CNT_W-1:0]                  hold_cnt;
    logic [1:0]                        last_owner;

    logic [NUM_REQ-1:0][DATA_W-1:0]    slices;
    logic [NUM_REQ-1:0]                cand_c;
    logic                              found_c;
    logic [1:0]                        winner_c;
    logic [DATA_W-1:0]                 own_data_c;

    assign slices = ReqData;

    // Per-digit enables for a display value; digit 0 always shown.
    function automatic logic [DIGITS-1:0] digit_enables(input logic [DATA_W-1:0] d,
                                                        input logic            blank);
        logic [DIGITS-1:0] en;
        en = '1;
        if (blank) begin
            for (int k = 1; k < int'(DIGITS); k++) begin
                en[k] = |(d >> (4 * k));
            end
        end
        return en;
    endfunction

    // Round-robin search from last_owner+1 with wrap; in SHOW the owner is
    // excluded so only a different requester can win a switch.
    always_comb begin
        cand_c   = (state == SHOW) ? (Req & ~Grant) : Req;
        found_c  = 1'b0;
        winner_c = last_owner;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            logic [1:0] idx;
            idx = 2'((32'(last_owner) + 32'(i)) % 32'(NUM_REQ));
            if (!found_c && cand_c[idx]) begin
                found_c  = 1'b1;
                winner_c = idx;
            end
        end
    end

    // Owner keeps tracking its slice while requesting, otherwise holds.
    always_comb begin
        own_data_c = Data;
        if (Req[last_owner]) begin
            own_data_c = slices[last_owner];
        end
    end

    // Arbitration state, hold counter and registered display outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            Grant          <= '0;
            Data           <= '0;
            DisplayEnables <= '0;
            HoldDone       <= 1'b0;
            hold_cnt       <= '0;
            last_owner     <= 2'd2;
        end else if (Clear) begin
            // Pointer is kept so fairness survives a clear.
            state          <= IDLE;
            Grant          <= '0;
            Data           <= '0;
            DisplayEnables <= '0;
            HoldDone       <= 1'b0;
            hold_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found_c) begin
                        state          <= SHOW;
                        last_owner     <= winner_c;
                        Grant          <= 3'b001 << winner_c;
                        Data           <= slices[winner_c];
                        DisplayEnables <= digit_enables(slices[winner_c], BlankZeros);
                        hold_cnt       <= HOLD_LOAD;
                        HoldDone       <= (HOLD_LOAD == '0);
                    end
                end
                SHOW: begin
                    if ((hold_cnt == '0) && found_c) begin
                        last_owner     <= winner_c;
                        Grant          <= 3'b001 << winner_c;
                        Data           <= slices[winner_c];
                        DisplayEnables <= digit_enables(slices[winner_c], BlankZeros);
                        hold_cnt       <= HOLD_LOAD;
                        HoldDone       <= (HOLD_LOAD == '0);
                    end else begin
                        if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - CNT_W'(1);
                        end
                        // Reflects the counter value being written this edge.
                        HoldDone       <= (hold_cnt <= CNT_W'(1));
                        Data           <= own_data_c;
                        DisplayEnables <= digit_enables(own_data_c, BlankZeros);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segs_arbiter.sv
// Testbench for segs_arbiter: directed vector table, hand-written timing
// sequences and randomized stimulus against a behavioural model. Two
// instances run in parallel with HOLD_CYCLES 4 and 2.
module tb_segs_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [2:0]  Req;
    logic [71:0] ReqData;
    logic        BlankZeros;
    logic        Clear;

    logic [2:0]  g4, g2;
    logic [23:0] d4, d2;
    logic [5:0]  e4, e2;
    logic        h4, h2;

    int n_pass  = 0;
    int n_total = 0;

    segs_arbiter #(.HOLD_CYCLES(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .Req(Req), .ReqData(ReqData),
        .BlankZeros(BlankZeros), .Clear(Clear),
        .Grant(g4), .Data(d4), .DisplayEnables(e4), .HoldDone(h4)
    );

    segs_arbiter #(.HOLD_CYCLES(2)) dut2 (
        .Clock(Clock), .Reset(Reset), .Req(Req), .ReqData(ReqData),
        .BlankZeros(BlankZeros), .Clear(Clear),
        .Grant(g2), .Data(d2), .DisplayEnables(e2), .HoldDone(h2)
    );

    always #5 Clock = ~Clock;

    // ---------------- behavioural model (index 0: hold 4, 1: hold 2) ----
    int          m_hold [2] = '{4, 2};
    int          m_owner[2];
    int          m_left [2];
    int          m_last [2];
    logic [23:0] m_data [2];
    logic [5:0]  m_en   [2];
    logic        m_hd   [2];

    // Number of significant digits decides how many low digits light up.
    function automatic logic [5:0] exp_en(input logic [23:0] d, input logic bz);
        int n;
        if (!bz) return 6'h3F;
        n = 1;
        for (int i = 0; i < 6; i++) begin
            if (((d >> (4 * i)) & 24'hF) != 24'h0) n = i + 1;
        end
        return 6'((1 << n) - 1);
    endfunction

    function automatic int rr_pick(input logic [2:0] r, input int last);
        for (int s = 1; s <= 3; s++) begin
            int c;
            c = (last + s) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [23:0] slice_of(input int i);
        return ReqData[24 * i +: 24];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_left[k]  = 0;
            m_last[k]  = 2;
            m_data[k]  = '0;
            m_en[k]    = '0;
            m_hd[k]    = 1'b0;
        end
    endtask

    task automatic grant_to(input int k, input int w);
        m_owner[k] = w;
        m_last[k]  = w;
        m_left[k]  = m_hold[k] - 1;
        m_data[k]  = slice_of(w);
        m_en[k]    = exp_en(m_data[k], BlankZeros);
        m_hd[k]    = (m_left[k] == 0);
    endtask

    // Apply the rules to the inputs present at the coming clock edge.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [2:0] others;
            int w;
            if (Clear) begin
                m_owner[k] = -1;
                m_left[k]  = 0;
                m_data[k]  = '0;
                m_en[k]    = '0;
                m_hd[k]    = 1'b0;
            end else if (m_owner[k] < 0) begin
                w = rr_pick(Req, m_last[k]);
                if (w >= 0) grant_to(k, w);
            end else begin
                others = Req;
                others[m_owner[k]] = 1'b0;
                w = rr_pick(others, m_last[k]);
                if (m_left[k] == 0 && w >= 0) begin
                    grant_to(k, w);
                end else begin
                    if (m_left[k] > 0) m_left[k]--;
                    if (Req[m_owner[k]]) m_data[k] = slice_of(m_owner[k]);
                    m_en[k] = exp_en(m_data[k], BlankZeros);
                    m_hd[k] = (m_left[k] == 0);
                end
            end
        end
    endtask

    function automatic logic [2:0] m_grant(input int k);
        return (m_owner[k] < 0) ? 3'b000 : 3'(3'b001 << m_owner[k]);
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " h4 grant"}, 32'(g4), 32'(m_grant(0)));
        chk({tag, " h4 data"},  32'(d4), 32'(m_data[0]));
        chk({tag, " h4 en"},    32'(e4), 32'(m_en[0]));
        chk({tag, " h4 done"},  32'(h4), 32'(m_hd[0]));
        chk({tag, " h2 grant"}, 32'(g2), 32'(m_grant(1)));
        chk({tag, " h2 data"},  32'(d2), 32'(m_data[1]));
        chk({tag, " h2 en"},    32'(e2), 32'(m_en[1]));
        chk({tag, " h2 done"},  32'(h2), 32'(m_hd[1]));
    endtask

    task automatic step();
        model_edge();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Req        = '0;
        ReqData    = '0;
        BlankZeros = 1'b0;
        Clear      = 1'b0;
        Reset      = 1'b1;
        model_reset();
        @(negedge Clock);
        Reset = 1'b0;
        step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  req;
        logic [23:0] d0;
        logic        bz;
        logic [2:0]  g;
        logic [23:0] d;
        logic [5:0]  en;
    } vec_t;

    vec_t vt[8];

    logic [2:0]  rr_exp[7];
    logic [23:0] rr_dat[3];

    initial begin
        vt[0] = '{3'b001, 24'h123456, 1'b0, 3'b001, 24'h123456, 6'b111111};
        vt[1] = '{3'b001, 24'h00ABCD, 1'b0, 3'b001, 24'h00ABCD, 6'b111111};
        vt[2] = '{3'b001, 24'h000120, 1'b1, 3'b001, 24'h000120, 6'b000111};
        vt[3] = '{3'b001, 24'h000000, 1'b1, 3'b001, 24'h000000, 6'b000001};
        vt[4] = '{3'b001, 24'h800000, 1'b1, 3'b001, 24'h800000, 6'b111111};
        vt[5] = '{3'b001, 24'h00ABCD, 1'b1, 3'b001, 24'h00ABCD, 6'b001111};
        vt[6] = '{3'b000, 24'h111111, 1'b1, 3'b001, 24'h00ABCD, 6'b001111};
        vt[7] = '{3'b000, 24'h111111, 1'b0, 3'b001, 24'h00ABCD, 6'b111111};

        rr_exp = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
        rr_dat = '{24'h111111, 24'h222222, 24'h333333};

        // Reset state.
        do_reset();
        chk("reset grant", 32'(g4), 32'h0);
        chk("reset data",  32'(d4), 32'h0);
        chk("reset en",    32'(e4), 32'h0);
        chk("reset done",  32'(h4), 32'h0);

        // Table: single requester and leading-zero blanking.
        for (int i = 0; i < 8; i++) begin
            Req           = vt[i].req;
            ReqData       = {48'h0, vt[i].d0};
            BlankZeros    = vt[i].bz;
            step();
            chk($sformatf("vec%0d grant", i), 32'(g4), 32'(vt[i].g));
            chk($sformatf("vec%0d data", i),  32'(d4), 32'(vt[i].d));
            chk($sformatf("vec%0d en", i),    32'(e4), 32'(vt[i].en));
        end

        // Asynchronous reset mid-operation with requester 1 owning.
        do_reset();
        Req     = 3'b010;
        ReqData = {24'h0, 24'h654321, 24'h0};
        step();
        chk("pre-reset grant", 32'(g4), 32'h2);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        chk("async reset grant", 32'(g4), 32'h0);
        chk("async reset data",  32'(d4), 32'h0);
        chk("async reset en",    32'(e4), 32'h0);
        chk("async reset done",  32'(h4), 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        Req   = 3'b000;
        step();
        chk("post-reset idle grant", 32'(g4), 32'h0);
        chk("post-reset idle data",  32'(d4), 32'h0);

        // Hold enforcement with HOLD_CYCLES=4.
        do_reset();
        Req     = 3'b001;
        ReqData = {24'h0, 24'hBBBBBB, 24'hAAAAAA};
        step();
        chk("hold g grant", 32'(g4), 32'h1);
        chk("hold g done",  32'(h4), 32'h0);
        Req = 3'b011;
        step();
        chk("hold g+1 grant", 32'(g4), 32'h1);
        chk("hold g+1 done",  32'(h4), 32'h0);
        step();
        chk("hold g+2 grant", 32'(g4), 32'h1);
        chk("hold g+2 done",  32'(h4), 32'h0);
        step();
        chk("hold g+3 grant", 32'(g4), 32'h1);
        chk("hold g+3 done",  32'(h4), 32'h1);
        step();
        chk("hold g+4 grant", 32'(g4), 32'h2);
        chk("hold g+4 data",  32'(d4), 32'hBBBBBB);
        chk("hold g+4 done",  32'(h4), 32'h0);

        // Round-robin with HOLD_CYCLES=2, all requesting.
        do_reset();
        Req     = 3'b111;
        ReqData = {rr_dat[2], rr_dat[1], rr_dat[0]};
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("rr%0d grant", i), 32'(g2), 32'(rr_exp[i]));
            chk($sformatf("rr%0d data", i),  32'(d2),
                32'((rr_exp[i] == 3'b001) ? rr_dat[0] :
                    (rr_exp[i] == 3'b010) ? rr_dat[1] : rr_dat[2]));
        end

        // Clear mid-hold, then re-grant.
        do_reset();
        Req     = 3'b010;
        ReqData = {24'h0, 24'h0C0FFE, 24'h0};
        step();
        chk("clr pre grant", 32'(g4), 32'h2);
        step();
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        chk("clr grant", 32'(g4), 32'h0);
        chk("clr data",  32'(d4), 32'h0);
        chk("clr en",    32'(e4), 32'h0);
        step();
        chk("clr regrant", 32'(g4), 32'h2);
        chk("clr regrant data", 32'(d4), 32'h0C0FFE);

        // Randomized stimulus against the model.
        do_reset();
        chk_model("rnd start");
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) Req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) BlankZeros = 1'($urandom_range(0, 1));
            Clear = ($urandom_range(0, 49) == 0);
            for (int r = 0; r < 3; r++) begin
                logic [23:0] v;
                v = 24'($urandom);
                if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(0, 6));
                ReqData[24 * r +: 24] = v;
            end
            step();
            chk_model($sformatf("rnd%0d", c));
        end
        Clear = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
